// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg - shared types and constants for the memory port arbiter.
//   arb_state_t   : sequencer states (IDLE, ACCESS, RDATA)
//   req_t         : one captured request (we, addr, wdata) at the default widths
//   RR_RESET_LAST : last-grant value after reset; 1 lets requester 0 win the first tie
package mem_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam logic RR_RESET_LAST = 1'b1;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// mem_arb_rr_pick - combinational two-way round-robin pick.
// Ports:
//   valid[1:0]      : request lines of requester 0 and 1
//   last_gnt        : index of the requester granted most recently
//   gnt_onehot[1:0] : one-hot winner, all zero when nothing is valid
//   gnt_idx         : index of the winner (0 when nothing is valid)
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_gnt,
  output logic [1:0] gnt_onehot,
  output logic       gnt_idx
);

  always_comb begin
    gnt_onehot = 2'b00;
    gnt_idx    = 1'b0;
    case (valid)
      2'b01: begin
        gnt_onehot = 2'b01;
        gnt_idx    = 1'b0;
      end
      2'b10: begin
        gnt_onehot = 2'b10;
        gnt_idx    = 1'b1;
      end
      2'b11: begin
        // Tie: whoever was not served last goes first.
        gnt_idx    = ~last_gnt;
        gnt_onehot = last_gnt ? 2'b01 : 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter - round-robin arbiter and sequencer placing two requesters
// in front of a single-port memory with registered read data.
// Optional feature: define MEM_ARB_STATS_EN to add saturating per-requester
// grant counters r0_grant_cnt / r1_grant_cnt.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   rN_valid/rN_ready          : request handshake (ready combinational, IDLE only)
//   rN_we, rN_addr, rN_wdata   : request payload (1 = write)
//   rN_rvalid, rN_rdata        : one-cycle read return to the owning requester
//   mem_addr/wr_en/rd_en/wdata : registered drive of the memory port
//   mem_rdata                  : registered read data from the memory
//   rN_grant_cnt               : accept counters (MEM_ARB_STATS_EN only)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  r0_grant_cnt,
  output logic [CNT_WIDTH-1:0]  r1_grant_cnt
`endif
);

  arb_state_t            state, state_nxt;
  logic                  last_gnt;
  logic                  owner;
  logic [1:0]            gnt_onehot;
  logic                  gnt_idx;
  logic                  accept;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  mem_arb_rr_pick u_pick (
    .valid      ({r1_valid, r0_valid}),
    .last_gnt   (last_gnt),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx)
  );

  assign sel_we    = gnt_idx ? r1_we    : r0_we;
  assign sel_addr  = gnt_idx ? r1_addr  : r0_addr;
  assign sel_wdata = gnt_idx ? r1_wdata : r0_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    r0_ready  = 1'b0;
    r1_ready  = 1'b0;
    case (state)
      IDLE: begin
        r0_ready = gnt_onehot[0];
        r1_ready = gnt_onehot[1];
        accept   = |gnt_onehot;
        if (accept) state_nxt = ACCESS;
      end
      // mem_rd_en is still high during ACCESS and tells read from write.
      ACCESS:  state_nxt = mem_rd_en ? RDATA : IDLE;
      RDATA:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accept edge: capture into the memory port; ACCESS end: drop enables;
  // RDATA end: hand the registered memory data to the owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt  <= RR_RESET_LAST;
      owner     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
    end else begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      if (accept) begin
        last_gnt  <= gnt_idx;
        owner     <= gnt_idx;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        mem_wr_en <= sel_we;
        mem_rd_en <= ~sel_we;
      end else if (state == ACCESS) begin
        mem_wr_en <= 1'b0;
        mem_rd_en <= 1'b0;
      end
      if (state == RDATA) begin
        if (owner) begin
          r1_rdata  <= mem_rdata;
          r1_rvalid <= 1'b1;
        end else begin
          r0_rdata  <= mem_rdata;
          r0_rvalid <= 1'b1;
        end
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r0_grant_cnt <= '0;
      r1_grant_cnt <= '0;
    end else if (accept) begin
      if (gnt_idx) r1_grant_cnt <= sat_inc(r1_grant_cnt);
      else         r0_grant_cnt <= sat_inc(r0_grant_cnt);
    end
  end
`endif

endmodule
